// File: rtl/writeback_pipe.sv
// Register-file write side: per-pipe shift pipelines align even/odd results to a common
// writeback stage, drive the regfile write ports and answer pending-write queries.
module writeback_pipe #(
  parameter int DEPTH = 7,
  parameter int AW    = 7,
  parameter int DW    = 128,
  parameter int NQ    = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             res_valid_even,
  input  logic [2:0]       res_stage_even,
  input  logic [AW-1:0]    res_addr_even,
  input  logic [DW-1:0]    res_data_even,
  input  logic             res_valid_odd,
  input  logic [2:0]       res_stage_odd,
  input  logic [AW-1:0]    res_addr_odd,
  input  logic [DW-1:0]    res_data_odd,
  input  logic             flush,
  input  logic [2:0]       flush_stage,
  input  logic [NQ*AW-1:0] qry_addr,
  output logic [NQ-1:0]    qry_pending,
  output logic             reg_write_even,
  output logic [AW-1:0]    rt_addr_even,
  output logic [DW-1:0]    rt_even,
  output logic             reg_write_odd,
  output logic [AW-1:0]    rt_addr_odd,
  output logic [DW-1:0]    rt_odd,
  output logic             collision_err
);

  localparam logic [2:0] DEPTH3 = 3'(DEPTH);

  logic collision_err_reg;

  // Pipe 0 is the even pipe, pipe 1 the odd pipe; both share identical slot logic.
  for (genvar gi = 0; gi < 2; gi++) begin : pipe_g
    logic          cap_valid;
    logic [2:0]    cap_stage;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;

    assign cap_valid = (gi == 0) ? res_valid_even : res_valid_odd;
    assign cap_stage = (gi == 0) ? res_stage_even : res_stage_odd;
    assign cap_addr  = (gi == 0) ? res_addr_even  : res_addr_odd;
    assign cap_data  = (gi == 0) ? res_data_even  : res_data_odd;

    logic          valid_reg   [1:DEPTH];
    logic [AW-1:0] addr_reg    [1:DEPTH];
    logic [DW-1:0] data_reg    [1:DEPTH];
    logic          valid_next  [1:DEPTH];
    logic [AW-1:0] addr_next   [1:DEPTH];
    logic [DW-1:0] data_next   [1:DEPTH];
    logic          shift_valid [1:DEPTH];

    logic          dropped;
    logic          legal;
    logic          err_hit;
    logic [NQ-1:0] hit;

    // Flush drops younger inputs before they can collide or flag an illegal stage.
    assign dropped = flush && (cap_stage < flush_stage);
    assign legal   = (cap_stage != 3'd0) && (cap_stage <= DEPTH3);

    always_comb begin
      err_hit = cap_valid && !dropped && !legal;
      for (int k = 1; k <= DEPTH; k++) begin
        if (k == 1) begin
          shift_valid[k] = 1'b0;
          addr_next[k]   = '0;
          data_next[k]   = '0;
        end else begin
          shift_valid[k] = valid_reg[k-1] && !(flush && (3'(k-1) < flush_stage));
          addr_next[k]   = addr_reg[k-1];
          data_next[k]   = data_reg[k-1];
        end
        valid_next[k] = shift_valid[k];
        if (cap_valid && !dropped && legal && (cap_stage == 3'(k))) begin
          valid_next[k] = 1'b1;
          addr_next[k]  = cap_addr;
          data_next[k]  = cap_data;
          if (shift_valid[k]) begin
            err_hit = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 1; k <= DEPTH; k++) begin
          valid_reg[k] <= 1'b0;
          addr_reg[k]  <= '0;
          data_reg[k]  <= '0;
        end
      end else begin
        for (int k = 1; k <= DEPTH; k++) begin
          valid_reg[k] <= valid_next[k];
          addr_reg[k]  <= addr_next[k];
          data_reg[k]  <= data_next[k];
        end
      end
    end

    always_comb begin
      hit = '0;
      for (int q = 0; q < NQ; q++) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (valid_reg[k] && (addr_reg[k] == qry_addr[q*AW +: AW])) begin
            hit[q] = 1'b1;
          end
        end
      end
    end
  end

  logic          wb_valid_even;
  logic          wb_valid_odd;
  logic [AW-1:0] wb_addr_even;
  logic [AW-1:0] wb_addr_odd;
  logic          same_addr_tie;

  assign wb_valid_even = pipe_g[0].valid_reg[DEPTH];
  assign wb_valid_odd  = pipe_g[1].valid_reg[DEPTH];
  assign wb_addr_even  = pipe_g[0].addr_reg[DEPTH];
  assign wb_addr_odd   = pipe_g[1].addr_reg[DEPTH];

  // Odd is the younger write of a bundle, so it wins a same-address tie.
  assign same_addr_tie = wb_valid_even && wb_valid_odd && (wb_addr_even == wb_addr_odd);

  assign reg_write_even = wb_valid_even && !same_addr_tie;
  assign rt_addr_even   = wb_valid_even ? wb_addr_even : '0;
  assign rt_even        = wb_valid_even ? pipe_g[0].data_reg[DEPTH] : '0;
  assign reg_write_odd  = wb_valid_odd;
  assign rt_addr_odd    = wb_valid_odd ? wb_addr_odd : '0;
  assign rt_odd         = wb_valid_odd ? pipe_g[1].data_reg[DEPTH] : '0;

  assign qry_pending = pipe_g[0].hit | pipe_g[1].hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_err_reg <= 1'b0;
    end else if (pipe_g[0].err_hit || pipe_g[1].err_hit) begin
      collision_err_reg <= 1'b1;
    end
  end

  assign collision_err = collision_err_reg;

endmodule

// File: tb/tb_writeback_pipe.sv
// Scoreboard bench for writeback_pipe: directed issues push cycle-stamped expected writes,
// a negedge monitor pops and compares write ports, pending queries and the error flag.
module tb_writeback_pipe;
  localparam int DEPTH = 7;
  localparam int AW    = 7;
  localparam int DW    = 128;
  localparam int NQ    = 6;

  logic             clk;
  logic             reset;
  logic             res_valid_even;
  logic [2:0]       res_stage_even;
  logic [AW-1:0]    res_addr_even;
  logic [DW-1:0]    res_data_even;
  logic             res_valid_odd;
  logic [2:0]       res_stage_odd;
  logic [AW-1:0]    res_addr_odd;
  logic [DW-1:0]    res_data_odd;
  logic             flush;
  logic [2:0]       flush_stage;
  logic [NQ*AW-1:0] qry_addr;
  logic [NQ-1:0]    qry_pending;
  logic             reg_write_even;
  logic [AW-1:0]    rt_addr_even;
  logic [DW-1:0]    rt_even;
  logic             reg_write_odd;
  logic [AW-1:0]    rt_addr_odd;
  logic [DW-1:0]    rt_odd;
  logic             collision_err;

  writeback_pipe #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .NQ(NQ)) dut (
    .clk(clk), .reset(reset),
    .res_valid_even(res_valid_even), .res_stage_even(res_stage_even),
    .res_addr_even(res_addr_even), .res_data_even(res_data_even),
    .res_valid_odd(res_valid_odd), .res_stage_odd(res_stage_odd),
    .res_addr_odd(res_addr_odd), .res_data_odd(res_data_odd),
    .flush(flush), .flush_stage(flush_stage), .qry_addr(qry_addr),
    .qry_pending(qry_pending),
    .reg_write_even(reg_write_even), .rt_addr_even(rt_addr_even), .rt_even(rt_even),
    .reg_write_odd(reg_write_odd), .rt_addr_odd(rt_addr_odd), .rt_odd(rt_odd),
    .collision_err(collision_err)
  );

  typedef struct {
    int            t;
    bit            odd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  bit            err_set = 0;
  int            err_at = 0;
  logic [AW-1:0] qa [NQ] = '{7'd17, 7'd5, 7'd3, 7'd4, 7'd9, 7'd21};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic note_err(input int n);
    if (!err_set) begin
      err_set = 1;
      err_at  = n + 1;
    end
  endtask

  task automatic model_cap(input bit p, input bit v, input int s, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit fl, input int fs, input int n);
    exp_t e;
    if (!v) return;
    if (fl && s < fs) return;
    if (s < 1 || s > DEPTH) begin
      note_err(n);
      return;
    end
    e.t = n + 1 + DEPTH - s;
    e.odd = p;
    e.a = a;
    e.d = d;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].odd == p && sb[i].t == e.t) begin
        sb.delete(i);
        note_err(n);
      end
    end
    sb.push_back(e);
  endtask

  // Called just after a negedge; inputs are captured at the next posedge.
  task automatic issue(input bit ve, input int se, input logic [AW-1:0] ae, input logic [DW-1:0] de,
                       input bit vo, input int so, input logic [AW-1:0] ao, input logic [DW-1:0] dd,
                       input bit fl, input int fs);
    int n;
    n = cyc;
    res_valid_even = ve; res_stage_even = 3'(se); res_addr_even = ae; res_data_even = de;
    res_valid_odd  = vo; res_stage_odd  = 3'(so); res_addr_odd  = ao; res_data_odd  = dd;
    flush = fl; flush_stage = 3'(fs);
    if (fl) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].t >= n + DEPTH - fs + 1 && sb[i].t <= n + DEPTH - 1) sb.delete(i);
      end
    end
    model_cap(1'b0, ve, se, ae, de, fl, fs, n);
    model_cap(1'b1, vo, so, ao, dd, fl, fs, n);
    @(negedge clk); #1;
    res_valid_even = 1'b0; res_valid_odd = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk); #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    int ie, io;
    logic we, wo;
    logic [NQ-1:0] eq;
    ie = -1; io = -1; eq = '0;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].t == cyc) begin
        if (sb[i].odd) io = i; else ie = i;
      end
      for (int q = 0; q < NQ; q++) begin
        if (sb[i].t >= cyc && sb[i].t - cyc <= DEPTH - 1 && sb[i].a == qa[q]) eq[q] = 1'b1;
      end
    end
    we = (ie >= 0) && !((io >= 0) && sb[ie].a == sb[io].a);
    wo = (io >= 0);
    chk("reg_write_even", DW'(reg_write_even), DW'(we));
    chk("rt_addr_even", DW'(rt_addr_even), (ie >= 0) ? DW'(sb[ie].a) : '0);
    chk("rt_even", rt_even, (ie >= 0) ? sb[ie].d : '0);
    chk("reg_write_odd", DW'(reg_write_odd), DW'(wo));
    chk("rt_addr_odd", DW'(rt_addr_odd), (io >= 0) ? DW'(sb[io].a) : '0);
    chk("rt_odd", rt_odd, (io >= 0) ? sb[io].d : '0);
    chk("qry_pending", DW'(qry_pending), DW'(eq));
    chk("collision_err", DW'(collision_err), DW'(err_set && cyc >= err_at));
    if (ie > io) begin
      sb.delete(ie);
      if (io >= 0) sb.delete(io);
    end else if (io >= 0) begin
      sb.delete(io);
      if (ie >= 0) sb.delete(ie);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    res_valid_even = 1'b0; res_stage_even = '0; res_addr_even = '0; res_data_even = '0;
    res_valid_odd  = 1'b0; res_stage_odd  = '0; res_addr_odd  = '0; res_data_odd  = '0;
    flush = 1'b0; flush_stage = '0;
    for (int q = 0; q < NQ; q++) qry_addr[q*AW +: AW] = qa[q];
    idle(3);
    reset = 1'b1;

    // Single even write, S=2: six cycles to the write port, high for one cycle.
    issue(1, 2, 7'd5, {16{8'hAA}}, 0, 0, 7'd0, '0, 0, 0);
    idle(8);
    // Both pipes in one bundle with different stages.
    issue(1, 2, 7'd3, {8{16'h1234}}, 1, 6, 7'd4, {4{32'hCAFEF00D}}, 0, 0);
    idle(8);
    // Same address reaching slot DEPTH in both pipes: odd wins.
    issue(1, 7, 7'd9, {16{8'h11}}, 1, 7, 7'd9, {16{8'h22}}, 0, 0);
    idle(3);
    // Entries in slots 6 (even), 4 (odd), 2 (even), then flush F=4.
    issue(1, 5, 7'd22, {16{8'h33}}, 1, 3, 7'd21, {16{8'h44}}, 0, 0);
    issue(1, 2, 7'd20, {16{8'h55}}, 0, 0, 7'd0, '0, 0, 0);
    issue(1, 5, 7'd26, {16{8'h66}}, 1, 2, 7'd25, {16{8'h77}}, 1, 4);
    idle(9);
    // Entry in slot 3 collides with an S=4 input at the next edge.
    issue(1, 3, 7'd30, {16{8'h88}}, 0, 0, 7'd0, '0, 0, 0);
    issue(1, 4, 7'd31, {16{8'h99}}, 0, 0, 7'd0, '0, 0, 0);
    idle(7);
    // Address 17 in flight, then asynchronous reset mid-flight.
    issue(1, 1, 7'd17, {16{8'hBB}}, 0, 0, 7'd0, '0, 0, 0);
    idle(3);
    @(posedge clk); #2;
    chk("pre_reset_qry17", DW'(qry_pending[0]), DW'(1'b1));
    chk("pre_reset_err", DW'(collision_err), DW'(1'b1));
    reset = 1'b0;
    #1;
    chk("rst_reg_write_even", DW'(reg_write_even), '0);
    chk("rst_reg_write_odd", DW'(reg_write_odd), '0);
    chk("rst_rt_addr_even", DW'(rt_addr_even), '0);
    chk("rst_rt_addr_odd", DW'(rt_addr_odd), '0);
    chk("rst_rt_even", rt_even, '0);
    chk("rst_rt_odd", rt_odd, '0);
    chk("rst_qry_pending", DW'(qry_pending), '0);
    chk("rst_collision_err", DW'(collision_err), '0);
    sb.delete();
    err_set = 0;
    idle(2);
    reset = 1'b1;
    // Illegal stage 0 sets the error and writes nothing; a legal odd S=7 still writes.
    issue(1, 0, 7'd50, {16{8'hCC}}, 1, 7, 7'd60, {16{8'hDD}}, 0, 0);
    idle(9);
    chk("scoreboard_empty", DW'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
